univ_shift_reg: RTL and testbench

//  Parametrised universal shift register: parallel load, parallel readout and an

---
 rtl/univ_shift_reg.sv | 98 +++++++++
 tb/tb_univ_shift_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, parallel readout and a counted
// serial shift burst in either direction, with busy/done status.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] PI,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] shift_len,
    input  logic             sin,
    output logic [WIDTH-1:0] PO,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] WidthCnt = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] OneCnt   = CNT_W'(1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] po_q, po_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;

    // Next-state: clr first, then the burst, then load/start while idle.
    always_comb begin
        state_d = state_q;
        po_d    = po_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (clr) begin
            state_d = StIdle;
            po_d    = '0;
            cnt_d   = '0;
            dir_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        po_d = PI;
                    end else if (start) begin
                        if (shift_len == '0) begin
                            // Empty burst completes at once.
                            done_d = 1'b1;
                        end else begin
                            dir_d   = dir;
                            cnt_d   = (shift_len > WidthCnt) ? WidthCnt : shift_len;
                            state_d = StShift;
                        end
                    end
                end
                StShift: begin
                    po_d  = dir_q ? {po_q[WIDTH-2:0], sin} : {sin, po_q[WIDTH-1:1]};
                    cnt_d = cnt_q - OneCnt;
                    if (cnt_q == OneCnt) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            po_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            po_q    <= po_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // Outputs; sout follows the live dir input while idle, the latched one while shifting.
    always_comb begin
        PO   = po_q;
        busy = (state_q == StShift);
        done = done_q;
        sout = (busy ? dir_q : dir) ? po_q[WIDTH-1] : po_q[0];
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH = 8).
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst, clr, load, start, dir, sin;
    logic [7:0] PI;
    logic [3:0] shift_len;
    logic [7:0] PO;
    logic       sout, busy, done;

    int checks = 0;
    int errors = 0;

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .load      (load),
        .PI        (PI),
        .start     (start),
        .dir       (dir),
        .shift_len (shift_len),
        .sin       (sin),
        .PO        (PO),
        .sout      (sout),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] val);
        load = 1'b1;
        PI   = val;
        tick();
        load = 1'b0;
    endtask

    logic [7:0] pat;
    logic [7:0] exp_po [3] = '{8'hD2, 8'hE9, 8'hF4};
    logic       exp_so [3] = '{1'b1, 1'b0, 1'b1};
    int         n;

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; start = 1'b0; dir = 1'b0; sin = 1'b0;
        PI = '0; shift_len = '0;
        tick(); tick();
        check("rst_po", 32'(PO), 'h0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b0;

        // Async reset mid-cycle.
        do_load(8'h3C);
        check("pre_rst_po", 32'(PO), 'h3C);
        #2 rst = 1'b1;
        #1;
        check("async_rst_po", 32'(PO), 'h0);
        check("async_rst_sout", 32'(sout), 0);
        rst = 1'b0;

        // Load and hold.
        do_load(8'hA5);
        check("load_po", 32'(PO), 'hA5);
        repeat (5) tick();
        check("hold_po", 32'(PO), 'hA5);

        // Right burst of 3 with sin=1.
        start = 1'b1; dir = 1'b0; shift_len = 4'd3; sin = 1'b1;
        tick();
        start = 1'b0;
        check("r_start_po", 32'(PO), 'hA5);
        for (int i = 0; i < 3; i++) begin
            check("r_sout", 32'(sout), 32'(exp_so[i]));
            check("r_busy", 32'(busy), 1);
            check("r_done_low", 32'(done), 0);
            tick();
            check("r_po", 32'(PO), 32'(exp_po[i]));
        end
        check("r_end_busy", 32'(busy), 0);
        check("r_end_done", 32'(done), 1);
        tick();
        check("r_done_pulse", 32'(done), 0);

        // Left burst of 8 with sin=0; dir toggled mid-burst.
        do_load(8'hA5);
        pat = 8'hA5;
        start = 1'b1; dir = 1'b1; shift_len = 4'd8; sin = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("l_sout", 32'(sout), 32'(pat[7-i]));
            tick();
            dir = ~dir;
        end
        check("l_po", 32'(PO), 'h00);
        check("l_busy", 32'(busy), 0);
        check("l_done", 32'(done), 1);
        tick();
        check("l_done_pulse", 32'(done), 0);
        dir = 1'b0;

        // Idle sout follows the live dir input.
        do_load(8'h80);
        check("idle_sout_r", 32'(sout), 0);
        dir = 1'b1;
        #1;
        check("idle_sout_l", 32'(sout), 1);
        dir = 1'b0;

        // Clamp: shift_len 12 gives 8 shifts; then back-to-back zero-length start.
        do_load(8'h5A);
        start = 1'b1; shift_len = 4'd12; sin = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check("clamp_count", 32'(n), 8);
        check("clamp_po", 32'(PO), 'hFF);
        check("clamp_done", 32'(done), 1);
        start = 1'b1; shift_len = 4'd0;
        tick();
        start = 1'b0;
        check("zero_po", 32'(PO), 'hFF);
        check("zero_busy", 32'(busy), 0);
        check("zero_done", 32'(done), 1);
        tick();
        check("zero_done_pulse", 32'(done), 0);

        // load/start during a burst are ignored.
        do_load(8'h81);
        start = 1'b1; dir = 1'b0; shift_len = 4'd4; sin = 1'b0;
        tick();
        start = 1'b0;
        tick();
        check("ign_po1", 32'(PO), 'h40);
        load = 1'b1; PI = 8'hFF; start = 1'b1; shift_len = 4'd1;
        tick();
        load = 1'b0; start = 1'b0;
        check("ign_po2", 32'(PO), 'h20);
        tick(); tick();
        check("ign_po4", 32'(PO), 'h08);
        check("ign_done", 32'(done), 1);
        tick();
        check("ign_idle_po", 32'(PO), 'h08);
        check("ign_idle_busy", 32'(busy), 0);

        // clr mid-burst aborts without done.
        do_load(8'hC3);
        start = 1'b1; dir = 1'b1; shift_len = 4'd5; sin = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("clr_pre_po", 32'(PO), 'h87);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_po", 32'(PO), 'h0);
        check("clr_busy", 32'(busy), 0);
        check("clr_done", 32'(done), 0);
        tick();
        check("clr_done_after", 32'(done), 0);
        check("clr_po_after", 32'(PO), 'h0);

        // rst mid-burst clears immediately.
        do_load(8'h3C);
        start = 1'b1; dir = 1'b0; shift_len = 4'd4; sin = 1'b0;
        tick();
        start = 1'b0;
        tick();
        check("rstb_pre_po", 32'(PO), 'h1E);
        #2 rst = 1'b1;
        #1;
        check("rstb_po", 32'(PO), 'h0);
        check("rstb_busy", 32'(busy), 0);
        check("rstb_sout", 32'(sout), 0);
        rst = 1'b0;
        tick();
        check("rstb_done", 32'(done), 0);
        check("rstb_busy_after", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
